fsmc_fifo_slave: RTL and testbench

//   Register-mapped slave on one chip-select of fsmc_interface's internal protocol (cs/addr_en/rd_en/wr_en).

---
 rtl/fsmc_fifo_slave.sv | 154 +++++++++++++++
 tb/tb_fsmc_fifo_slave.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsmc_fifo_slave.sv
// FSMC register-mapped slave that buffers a streaming sample source in a FIFO the MCU drains over the bus.
// Optional macro FSMC_FIFO_IRQ_EN enables the THRESH register and the level/overflow interrupt.
module fsmc_fifo_slave #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 256,
    parameter int CS_INDEX   = 0,
    parameter int CS_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CS_WIDTH-1:0]   cs,
    input  logic                  addr_en,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_STAT   = 4'h1;
    localparam logic [3:0] A_LEVEL  = 4'h2;
    localparam logic [3:0] A_FIFO   = 4'h3;
    localparam logic [3:0] A_THRESH = 4'h4;
    localparam logic [3:0] A_DROPS  = 4'h5;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [3:0]            addr_q;
    logic                  owned;
    logic                  wr_en_q;
    logic                  capture_en;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] drops;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic [DATA_WIDTH-1:0] rdata_next;
    logic                  sel;
    logic                  reg_wr;
    logic                  flush;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  push_try;
    logic                  push;
    logic                  drop;
    logic                  unused_inputs;

`ifdef FSMC_FIFO_IRQ_EN
    logic [DATA_WIDTH-1:0] thresh;
    logic [DATA_WIDTH-1:0] level_ext;
`endif

    assign sel      = cs[CS_INDEX];
    assign reg_wr   = rd_en & sel;
    assign flush    = reg_wr && (addr_q == A_CTRL) && bus_wdata[1];
    assign full     = (level == LW'(FIFO_DEPTH));
    assign empty    = (level == '0);
    // owned remembers whether the most recent address phase (any slave) targeted us,
    // so another slave's read strobe on the shared wr_en never pops our FIFO
    assign pop      = wr_en_q && !wr_en && owned && (addr_q == A_FIFO) && !empty;
    assign push_try = in_valid & capture_en;
    assign push     = push_try & (!full | pop);
    assign drop     = push_try & full & !pop;
    assign unused_inputs = ^{cs, bus_wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= 4'hF;
            owned      <= 1'b0;
            wr_en_q    <= 1'b0;
            capture_en <= 1'b0;
            overflow   <= 1'b0;
            drops      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
        end else begin
            wr_en_q <= wr_en;
            if (addr_en) begin
                owned <= sel;
                if (sel) addr_q <= bus_wdata[3:0];
            end
            if (reg_wr && addr_q == A_CTRL) capture_en <= bus_wdata[0];
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                drops    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)      level <= level + LW'(1);
                else if (pop && !push) level <= level - LW'(1);
                // a drop in the same cycle as a W1C clear wins so no overflow goes unreported
                if (drop) begin
                    overflow <= 1'b1;
                    if (drops != '1) drops <= drops + DATA_WIDTH'(1);
                end else if (reg_wr && addr_q == A_STAT && bus_wdata[2]) begin
                    overflow <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= in_data;
    end

`ifdef FSMC_FIFO_IRQ_EN
    assign level_ext = DATA_WIDTH'(level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh <= '0;
            irq    <= 1'b0;
        end else begin
            if (reg_wr && addr_q == A_THRESH) thresh <= bus_wdata;
            irq <= ((thresh != '0) && (level_ext >= thresh)) || overflow;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata_next = '0;
        case (addr_q)
            A_CTRL:  rdata_next[0] = capture_en;
            A_STAT: begin
                rdata_next[0] = empty;
                rdata_next[1] = full;
                rdata_next[2] = overflow;
            end
            A_LEVEL: rdata_next = DATA_WIDTH'(level);
            A_FIFO:  rdata_next = empty ? '0 : mem[rd_ptr];
`ifdef FSMC_FIFO_IRQ_EN
            A_THRESH: rdata_next = thresh;
`endif
            A_DROPS: rdata_next = drops;
            default: rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus_rdata <= '0;
        else        bus_rdata <= rdata_next;
    end
endmodule

// File: tb/tb_fsmc_fifo_slave.sv
// Directed, table-driven bench for fsmc_fifo_slave; honours FSMC_FIFO_IRQ_EN when defined.
module tb_fsmc_fifo_slave;
    localparam int DW    = 16;
    localparam int DEPTH = 256;

`ifdef FSMC_FIFO_IRQ_EN
    localparam logic [15:0] THRESH_EXP = 16'h0004;
    localparam logic [15:0] IRQ_ON     = 16'h0001;
`else
    localparam logic [15:0] THRESH_EXP = 16'h0000;
    localparam logic [15:0] IRQ_ON     = 16'h0000;
`endif

    typedef enum {OP_WRITE, OP_READ, OP_PUSH} op_t;
    typedef struct {
        op_t         op;
        bit          sel;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
        string       name;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    cs;
    logic          addr_en;
    logic          rd_en;
    logic          wr_en;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          irq;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    fsmc_fifo_slave #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .CS_INDEX(0),
        .CS_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cs(cs),
        .addr_en(addr_en),
        .rd_en(rd_en),
        .wr_en(wr_en),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .in_valid(in_valid),
        .in_data(in_data),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(op_t op, bit s, logic [3:0] a, logic [15:0] d, logic [15:0] e, string n);
        vec_t v;
        v.op = op; v.sel = s; v.addr = a; v.data = d; v.exp = e; v.name = n;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic bus_addr(input bit s, input logic [3:0] a);
        cs = s ? 4'b0001 : 4'b0010;
        addr_en = 1'b1;
        bus_wdata = {12'h000, a};
        @(negedge clk);
        addr_en = 1'b0;
    endtask

    task automatic bus_write(input bit s, input logic [3:0] a, input logic [15:0] d);
        bus_addr(s, a);
        rd_en = 1'b1;
        bus_wdata = d;
        @(negedge clk);
        rd_en = 1'b0;
        bus_wdata = '0;
        @(negedge clk);
        cs = '0;
    endtask

    // Optionally pushes a sample on exactly the edge where the read's pop lands
    task automatic bus_read(input bit s, input logic [3:0] a, input bit push_at_pop,
                            input logic [15:0] pdata, output logic [15:0] d);
        bus_addr(s, a);
        wr_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        d = bus_rdata;
        @(negedge clk);
        wr_en = 1'b0;
        if (push_at_pop) begin
            in_valid = 1'b1;
            in_data = pdata;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        cs = '0;
    endtask

    task automatic push_sample(input logic [15:0] d);
        in_valid = 1'b1;
        in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic read_check(input logic [3:0] a, input logic [15:0] exp, input string name);
        logic [15:0] got;
        bus_read(1'b1, a, 1'b0, 16'h0, got);
        checkOutput(name, got, exp);
    endtask

    task automatic applyStimulus(input vec_t t);
        case (t.op)
            OP_WRITE: bus_write(t.sel, t.addr, t.data);
            OP_PUSH:  push_sample(t.data);
            default: begin
                logic [15:0] got;
                bus_read(t.sel, t.addr, 1'b0, 16'h0, got);
                checkOutput(t.name, got, t.exp);
            end
        endcase
    endtask

    initial begin
        logic [15:0] got;
        rst_n = 1'b0; cs = '0; addr_en = 0; rd_en = 0; wr_en = 0;
        bus_wdata = '0; in_valid = 0; in_data = '0;

        vecs.push_back(mk(OP_READ,  1, 4'h1, 16'h0000, 16'h0001, "stat_reset"));
        vecs.push_back(mk(OP_READ,  1, 4'h2, 16'h0000, 16'h0000, "level_reset"));
        vecs.push_back(mk(OP_READ,  1, 4'h0, 16'h0000, 16'h0000, "ctrl_reset"));
        vecs.push_back(mk(OP_READ,  1, 4'h3, 16'h0000, 16'h0000, "fifo_reset_empty"));
        vecs.push_back(mk(OP_WRITE, 1, 4'h0, 16'h0001, 16'h0000, "ctrl_capture_on"));
        vecs.push_back(mk(OP_PUSH,  1, 4'h0, 16'h1111, 16'h0000, "push1"));
        vecs.push_back(mk(OP_PUSH,  1, 4'h0, 16'h2222, 16'h0000, "push2"));
        vecs.push_back(mk(OP_PUSH,  1, 4'h0, 16'h3333, 16'h0000, "push3"));
        vecs.push_back(mk(OP_READ,  1, 4'h2, 16'h0000, 16'h0003, "level_3"));
        vecs.push_back(mk(OP_READ,  1, 4'h1, 16'h0000, 16'h0000, "stat_nonempty"));
        vecs.push_back(mk(OP_READ,  1, 4'h3, 16'h0000, 16'h1111, "fifo_pop1"));
        vecs.push_back(mk(OP_READ,  1, 4'h3, 16'h0000, 16'h2222, "fifo_pop2"));
        vecs.push_back(mk(OP_READ,  1, 4'h3, 16'h0000, 16'h3333, "fifo_pop3"));
        vecs.push_back(mk(OP_READ,  1, 4'h1, 16'h0000, 16'h0001, "stat_drained"));
        vecs.push_back(mk(OP_READ,  1, 4'h2, 16'h0000, 16'h0000, "level_drained"));
        vecs.push_back(mk(OP_READ,  1, 4'h0, 16'h0000, 16'h0001, "ctrl_readback"));
        vecs.push_back(mk(OP_WRITE, 0, 4'h0, 16'h0000, 16'h0000, "ctrl_other_wr"));
        vecs.push_back(mk(OP_READ,  1, 4'h0, 16'h0000, 16'h0001, "ctrl_other_slave"));
        vecs.push_back(mk(OP_WRITE, 1, 4'h5, 16'h1234, 16'h0000, "drops_wr"));
        vecs.push_back(mk(OP_READ,  1, 4'h5, 16'h0000, 16'h0000, "drops_ro"));
        vecs.push_back(mk(OP_WRITE, 1, 4'h2, 16'h00FF, 16'h0000, "level_wr"));
        vecs.push_back(mk(OP_READ,  1, 4'h2, 16'h0000, 16'h0000, "level_ro"));
        vecs.push_back(mk(OP_READ,  1, 4'h7, 16'h0000, 16'h0000, "unmapped"));
        vecs.push_back(mk(OP_WRITE, 1, 4'h4, 16'h0004, 16'h0000, "thresh_wr"));
        vecs.push_back(mk(OP_READ,  1, 4'h4, 16'h0000, THRESH_EXP, "thresh_rd"));
        vecs.push_back(mk(OP_WRITE, 1, 4'h4, 16'h0000, 16'h0000, "thresh_clr"));

        repeat (2) @(negedge clk);
        checkOutput("rdata_in_reset", bus_rdata, 16'h0000);
        checkOutput("irq_in_reset", {15'h0, irq}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        // Overflow: DEPTH+5 samples with nobody draining
        for (int i = 0; i < DEPTH + 5; i++) push_sample(16'h1000 + 16'(i));
        read_check(4'h1, 16'h0006, "stat_overflow");
        checkOutput("irq_overflow", {15'h0, irq}, IRQ_ON);
        read_check(4'h2, 16'h0100, "level_full");
        read_check(4'h5, 16'h0005, "drops_5");
        bus_write(1'b1, 4'h1, 16'h0004);
        read_check(4'h1, 16'h0002, "stat_w1c");

        // Full FIFO: pop and push on the same edge, nothing dropped
        bus_read(1'b1, 4'h3, 1'b1, 16'hBEEF, got);
        checkOutput("fifo_full_pop_head", got, 16'h1000);
        read_check(4'h2, 16'h0100, "level_push_pop");
        read_check(4'h5, 16'h0005, "drops_unchanged");
        read_check(4'h1, 16'h0002, "stat_still_full");
        read_check(4'h3, 16'h1001, "fifo_next_head");
        bus_write(1'b1, 4'h0, 16'h0003);
        read_check(4'h2, 16'h0000, "level_flushed");
        read_check(4'h5, 16'h0000, "drops_flushed");
        read_check(4'h1, 16'h0001, "stat_flushed");
        read_check(4'h0, 16'h0001, "ctrl_flush_reads0");

        // Traffic for another slave must not move addr_q or pop
        push_sample(16'hAAAA);
        bus_addr(1'b1, 4'h3);
        cs = '0;
        @(negedge clk);
        bus_read(1'b0, 4'h1, 1'b0, 16'h0, got);
        checkOutput("addr_q_kept", bus_rdata, 16'hAAAA);
        read_check(4'h2, 16'h0001, "level_no_foreign_pop");
        bus_write(1'b0, 4'h0, 16'h0002);
        read_check(4'h2, 16'h0001, "level_no_foreign_flush");
        read_check(4'h3, 16'hAAAA, "fifo_own_pop");
        read_check(4'h3, 16'h0000, "fifo_empty_read");
        read_check(4'h2, 16'h0000, "level_after_empty_pop");

        // Threshold interrupt
        bus_write(1'b1, 4'h4, 16'h0004);
        for (int i = 1; i <= 3; i++) push_sample(16'h0A00 + 16'(i));
        repeat (2) @(negedge clk);
        checkOutput("irq_level3", {15'h0, irq}, 16'h0000);
        push_sample(16'h0A04);
        repeat (2) @(negedge clk);
        checkOutput("irq_level4", {15'h0, irq}, IRQ_ON);
        read_check(4'h3, 16'h0A01, "irq_pop_value");
        checkOutput("irq_after_pop", {15'h0, irq}, 16'h0000);

        // Reset in the middle of a FIFO read
        bus_addr(1'b1, 4'h3);
        wr_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rdata_mid_reset", bus_rdata, 16'h0000);
        checkOutput("irq_mid_reset", {15'h0, irq}, 16'h0000);
        @(negedge clk);
        wr_en = 1'b0;
        cs = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("addr_reset_unmapped", bus_rdata, 16'h0000);
        read_check(4'h1, 16'h0001, "stat_after_reset");
        read_check(4'h0, 16'h0000, "ctrl_after_reset");
        read_check(4'h4, 16'h0000, "thresh_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
